move_sched: RTL and testbench
=============================

MOVE_SCHED -- requirements
Module: move_sched

Interface
REQ-001 The block SHALL have parameter DROP_FRAMES, default 30, meaning frames between gravity steps (legal range 1..255).
REQ-002 The block SHALL have parameter COL_INIT, default 4, meaning the spawn column.
REQ-003 The block SHALL have parameter ROW_INIT, default 0, meaning the spawn row.
REQ-004 The block SHALL have parameter COL_MAX, default 9, meaning the rightmost legal column.
REQ-005 pclk  in  1  SHALL be the single clock; all logic is on its rising edge.
REQ-006 rst  in  1  SHALL be the reset: synchronous, active-low.
REQ-007 tick_frame  in  1  SHALL be a one-cycle pulse once per video frame.
REQ-008 req_left, req_right, req_rot, req_down  in  1 each  SHALL be one-cycle debounced button pulses.
REQ-009 chk_req  out  1  SHALL be the collision-query request to the playfield checker.
REQ-010 chk_col  out  5, chk_row  out  5, chk_rot  out  2  SHALL carry the candidate position.
REQ-011 chk_ack  in  1  SHALL be the checker's one-cycle completion pulse.
REQ-012 chk_ok  in  1  SHALL be the checker verdict, valid with chk_ack; 1 means the candidate is free.
REQ-013 piece_col  out  5, piece_row  out  5, piece_rot  out  2  SHALL carry the committed piece position to draw_rect.
REQ-014 lock  out  1  SHALL be a one-cycle pulse when the piece lands.
REQ-015 busy  out  1  SHALL be high whenever the state is not IDLE.

Function
REQ-016 A frame counter SHALL count tick_frame pulses 0..DROP_FRAMES-1. At terminal count plus a tick, it SHALL set grav_pend and wrap to 0.
REQ-017 Each of req_left/right/rot/down SHALL set its own pending flag. A pulse arriving while that flag is already set SHALL be merged, not counted.
REQ-018 Pending flags SHALL be set in any state, including while busy.
REQ-019 A request and a grant arriving in the same cycle SHALL leave the flag set.
REQ-020 The FSM SHALL have states IDLE, QUERY and RESOLVE.
REQ-021 IDLE SHALL grant the highest-priority pending flag, in this order: down (grav_pend OR down_pend), rot, left, right.
REQ-022 A grant SHALL clear only the granted flag(s). A down grant SHALL clear both grav_pend and down_pend.
REQ-023 A grant SHALL latch the candidate and go to QUERY on the next cycle.
REQ-024 Candidate values SHALL be:
  - left: col-1
  - right: col+1
  - down: row+1
  - rot: (rot+1) mod 4, with col/row unchanged.
REQ-025 A left grant at col 0, or a right grant at col COL_MAX, SHALL be discarded in IDLE with no query issued, and the state SHALL stay IDLE.
REQ-026 In QUERY, chk_req SHALL be high and chk_col/row/rot SHALL hold the candidate stable until chk_ack.
REQ-027 chk_ack SHALL be ignored in IDLE.
REQ-028 On chk_ack in QUERY, chk_req SHALL drop on the next cycle and the state SHALL go to RESOLVE, capturing chk_ok.
REQ-029 In RESOLVE with ok=1, the candidate SHALL commit to the piece_* outputs. A committed down SHALL also clear the frame counter to 0.
REQ-030 In RESOLVE with ok=0 on a down move:
  - lock SHALL pulse for one cycle;
  - piece_col/row/rot SHALL load COL_INIT/ROW_INIT/0;
  - all pending flags and the frame counter SHALL clear.
REQ-031 In RESOLVE with ok=0 on a non-down move, the position SHALL be unchanged.
REQ-032 RESOLVE SHALL always return to IDLE on the next cycle, so one move takes at least 3 cycles.
REQ-033 The piece_* outputs SHALL change only in RESOLVE, one cycle after chk_ack.
REQ-034 Column and row arithmetic SHALL be 5-bit unsigned with no wrap; row bounds are the checker's responsibility.

Reset
REQ-035 While rst=0 at a clock edge, the block SHALL load:
  - state IDLE;
  - all pending flags 0 and frame counter 0;
  - chk_req 0, lock 0, busy 0;
  - piece_col/chk_col COL_INIT, piece_row/chk_row ROW_INIT, piece_rot/chk_rot 0.
REQ-036 A reset asserted in QUERY SHALL abort the query; a chk_ack arriving after reset SHALL be ignored.

Verification
REQ-037 Gravity: DROP_FRAMES=3, no buttons, checker returns ok=1 with 2-cycle latency -> piece_row goes 0,1,2 on every 3rd tick_frame, and chk_req is high exactly 2 cycles per move.
REQ-038 Priority: req_left, req_rot and gravity all pending in the same cycle -> queries issued in order down, rot, left; final state col 3, row 1, rot 1.
REQ-039 Boundary: col=0, req_left -> no chk_req and position unchanged; col=9, req_right -> no chk_req.
REQ-040 Landing: row=5, down query answered ok=0 -> lock high exactly 1 cycle; then piece_col=4, piece_row=0, piece_rot=0, frame counter 0.
REQ-041 Merge/busy: three req_rot pulses during one outstanding query -> exactly one further rot query after return to IDLE.
REQ-042 Reset mid-query: rst=0 while chk_req=1 -> chk_req=0 and state IDLE next cycle; a later chk_ack causes no position change.

Source files
------------

// File: rtl/move_sched.sv
// Tetromino move scheduler: arbitrates gravity and button requests, asks the
// playfield checker about each candidate position and commits or locks the piece.
module move_sched #(
  parameter int DROP_FRAMES = 30,
  parameter int COL_INIT    = 4,
  parameter int ROW_INIT    = 0,
  parameter int COL_MAX     = 9
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       tick_frame,
  input  logic       req_left,
  input  logic       req_right,
  input  logic       req_rot,
  input  logic       req_down,
  output logic       chk_req,
  output logic [4:0] chk_col,
  output logic [4:0] chk_row,
  output logic [1:0] chk_rot,
  input  logic       chk_ack,
  input  logic       chk_ok,
  output logic [4:0] piece_col,
  output logic [4:0] piece_row,
  output logic [1:0] piece_rot,
  output logic       lock,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, QUERY, RESOLVE} state_t;
  typedef enum logic [1:0] {MV_DOWN, MV_ROT, MV_LEFT, MV_RIGHT} move_t;

  localparam logic [7:0] FRAME_LAST = 8'(DROP_FRAMES - 1);
  localparam logic [4:0] COL_INIT_V = 5'(COL_INIT);
  localparam logic [4:0] ROW_INIT_V = 5'(ROW_INIT);
  localparam logic [4:0] COL_MAX_V  = 5'(COL_MAX);

  state_t     state, state_nx;
  move_t      move_q, grant_mv;
  logic [7:0] frame_cnt;
  logic       grav_pend, down_pend, rot_pend, left_pend, right_pend;
  logic       ok_q;
  logic       grant_any, grant_blocked, grant_go;
  logic       landed, committed;
  logic [4:0] cand_col, cand_row;
  logic [1:0] cand_rot;

  // NOTE: every signal written in always_comb gets a default first, so no path
  // can leave it unassigned and infer a latch.
  always_comb begin
    grant_any = 1'b1;
    grant_mv  = MV_DOWN;
    cand_col  = piece_col;
    cand_row  = piece_row;
    cand_rot  = piece_rot;
    if (grav_pend || down_pend) begin
      grant_mv = MV_DOWN;
      cand_row = piece_row + 5'd1;
    end else if (rot_pend) begin
      grant_mv = MV_ROT;
      cand_rot = piece_rot + 2'd1;
    end else if (left_pend) begin
      grant_mv = MV_LEFT;
      cand_col = piece_col - 5'd1;
    end else if (right_pend) begin
      grant_mv = MV_RIGHT;
      cand_col = piece_col + 5'd1;
    end else begin
      grant_any = 1'b0;
    end
    // Off-board horizontal moves are dropped without bothering the checker.
    grant_blocked = (grant_mv == MV_LEFT  && piece_col == 5'd0) ||
                    (grant_mv == MV_RIGHT && piece_col == COL_MAX_V);
  end

  assign grant_go  = (state == IDLE) && grant_any && !grant_blocked;
  assign landed    = (state == RESOLVE) && !ok_q && (move_q == MV_DOWN);
  assign committed = (state == RESOLVE) && ok_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge pclk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (grant_go) state_nx = QUERY;
      QUERY:   if (chk_ack)  state_nx = RESOLVE;
      RESOLVE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    chk_req = (state == QUERY);
    busy    = (state != IDLE);
    lock    = landed;
  end

  // A grant clears its flag, but a request in the same cycle re-arms it.
  logic grav_set, clr_down, clr_rot, clr_left, clr_right;
  assign grav_set  = tick_frame && (frame_cnt == FRAME_LAST);
  assign clr_down  = landed || ((state == IDLE) && grant_any && grant_mv == MV_DOWN);
  assign clr_rot   = landed || ((state == IDLE) && grant_any && grant_mv == MV_ROT);
  assign clr_left  = landed || ((state == IDLE) && grant_any && grant_mv == MV_LEFT);
  assign clr_right = landed || ((state == IDLE) && grant_any && grant_mv == MV_RIGHT);

  always_ff @(posedge pclk) begin
    if (!rst) begin
      frame_cnt  <= '0;
      grav_pend  <= 1'b0;
      down_pend  <= 1'b0;
      rot_pend   <= 1'b0;
      left_pend  <= 1'b0;
      right_pend <= 1'b0;
      move_q     <= MV_DOWN;
      ok_q       <= 1'b0;
      chk_col    <= COL_INIT_V;
      chk_row    <= ROW_INIT_V;
      chk_rot    <= 2'd0;
      piece_col  <= COL_INIT_V;
      piece_row  <= ROW_INIT_V;
      piece_rot  <= 2'd0;
    end else begin
      if (landed || (committed && move_q == MV_DOWN)) frame_cnt <= '0;
      else if (tick_frame) frame_cnt <= (frame_cnt == FRAME_LAST) ? 8'd0 : frame_cnt + 8'd1;

      grav_pend  <= (grav_pend  && !clr_down)  || grav_set;
      down_pend  <= (down_pend  && !clr_down)  || req_down;
      rot_pend   <= (rot_pend   && !clr_rot)   || req_rot;
      left_pend  <= (left_pend  && !clr_left)  || req_left;
      right_pend <= (right_pend && !clr_right) || req_right;

      if (grant_go) begin
        move_q  <= grant_mv;
        chk_col <= cand_col;
        chk_row <= cand_row;
        chk_rot <= cand_rot;
      end

      if (state == QUERY && chk_ack) ok_q <= chk_ok;

      if (committed) begin
        piece_col <= chk_col;
        piece_row <= chk_row;
        piece_rot <= chk_rot;
      end else if (landed) begin
        piece_col <= COL_INIT_V;
        piece_row <= ROW_INIT_V;
        piece_rot <= 2'd0;
      end
    end
  end

endmodule

// File: tb/tb_move_sched.sv
// Bench for move_sched: table-driven moves, directed multi-cycle corner cases
// and a randomized run against a move-level reference model.
module tb_move_sched;

  localparam int DF      = 3;
  localparam int COL_MAX = 9;

  logic       pclk = 1'b0;
  logic       rst = 1'b0;
  logic       tick_frame = 1'b0;
  logic       req_left = 1'b0, req_right = 1'b0, req_rot = 1'b0, req_down = 1'b0;
  logic       chk_req;
  logic [4:0] chk_col, chk_row;
  logic [1:0] chk_rot;
  logic       chk_ack = 1'b0, chk_ok = 1'b0;
  logic [4:0] piece_col, piece_row;
  logic [1:0] piece_rot;
  logic       lock, busy;

  move_sched #(.DROP_FRAMES(DF), .COL_INIT(4), .ROW_INIT(0), .COL_MAX(COL_MAX)) dut (
    .pclk(pclk), .rst(rst), .tick_frame(tick_frame),
    .req_left(req_left), .req_right(req_right), .req_rot(req_rot), .req_down(req_down),
    .chk_req(chk_req), .chk_col(chk_col), .chk_row(chk_row), .chk_rot(chk_rot),
    .chk_ack(chk_ack), .chk_ok(chk_ok),
    .piece_col(piece_col), .piece_row(piece_row), .piece_rot(piece_rot),
    .lock(lock), .busy(busy)
  );

  always #5 pclk = ~pclk;

  int vec_n = 0, err_n = 0;
  int req_cnt = 0, lock_cnt = 0, q_run = 0, srv_lat = 2;
  bit srv_ok = 1'b1;
  logic [11:0] qlog[$];

  task automatic check(input string name, input int act, input int exp);
    vec_n++;
    if (act !== exp) begin
      err_n++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock; the bench checker answers on the srv_lat-th cycle of chk_req.
  task automatic cyc();
    @(posedge pclk);
    @(negedge pclk);
    if (chk_req) begin
      q_run++;
      req_cnt++;
      if (q_run == 1) qlog.push_back({chk_col, chk_row, chk_rot});
    end else begin
      q_run = 0;
    end
    if (lock) lock_cnt++;
    chk_ack = chk_req && (q_run == srv_lat);
    chk_ok  = srv_ok;
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic pulse(input bit l, input bit r, input bit ro, input bit d, input bit t);
    req_left = l; req_right = r; req_rot = ro; req_down = d; tick_frame = t;
    cyc();
    req_left = 0; req_right = 0; req_rot = 0; req_down = 0; tick_frame = 0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cyc();
    cyc();
    rst = 1'b1;
    req_cnt = 0; lock_cnt = 0; q_run = 0; srv_lat = 2; srv_ok = 1'b1;
    qlog.delete();
  endtask

  typedef struct {
    int btn;      // 0 down, 1 rot, 2 left, 3 right
    bit ok;
    int col, row, rot;
    bit queried;
  } vec_t;

  // Reference model state for the randomized run
  typedef enum {M_IDLE, M_WAIT, M_DONE} mphase_t;
  mphase_t m_phase;
  int  m_col, m_row, m_rot, m_frames, m_mv, c_col, c_row, c_rot;
  bit  m_ok, w_down, w_rot, w_left, w_right;

  task automatic model_step();
    bit s_down, c_d, c_r, c_l, c_rt, fclr;
    s_down = req_down || (tick_frame && m_frames == DF - 1);
    c_d = 0; c_r = 0; c_l = 0; c_rt = 0; fclr = 0;
    case (m_phase)
      M_IDLE: if (w_down || w_rot || w_left || w_right) begin
        c_col = m_col; c_row = m_row; c_rot = m_rot;
        if (w_down)     begin m_mv = 0; c_d = 1;  c_row = m_row + 1; end
        else if (w_rot) begin m_mv = 1; c_r = 1;  c_rot = (m_rot + 1) % 4; end
        else if (w_left) begin m_mv = 2; c_l = 1; c_col = m_col - 1; end
        else            begin m_mv = 3; c_rt = 1; c_col = m_col + 1; end
        if (!(m_mv == 2 && m_col == 0) && !(m_mv == 3 && m_col == COL_MAX))
          m_phase = M_WAIT;
      end
      M_WAIT: if (chk_ack) begin m_ok = chk_ok; m_phase = M_DONE; end
      M_DONE: begin
        if (m_ok) begin
          m_col = c_col; m_row = c_row; m_rot = c_rot;
          if (m_mv == 0) fclr = 1;
        end else if (m_mv == 0) begin
          m_col = 4; m_row = 0; m_rot = 0;
          c_d = 1; c_r = 1; c_l = 1; c_rt = 1; fclr = 1;
        end
        m_phase = M_IDLE;
      end
      default: m_phase = M_IDLE;
    endcase
    if (fclr) m_frames = 0;
    else if (tick_frame) m_frames = (m_frames == DF - 1) ? 0 : m_frames + 1;
    w_down  = (w_down  && !c_d)  || s_down;
    w_rot   = (w_rot   && !c_r)  || req_rot;
    w_left  = (w_left  && !c_l)  || req_left;
    w_right = (w_right && !c_rt) || req_right;
  endtask

  initial begin
    vec_t tbl[14];
    int r0;
    tbl[0]  = '{3, 1, 5, 0, 0, 1};
    tbl[1]  = '{1, 1, 5, 0, 1, 1};
    tbl[2]  = '{2, 1, 4, 0, 1, 1};
    tbl[3]  = '{0, 1, 4, 1, 1, 1};
    tbl[4]  = '{1, 0, 4, 1, 1, 1};
    tbl[5]  = '{2, 0, 4, 1, 1, 1};
    tbl[6]  = '{1, 1, 4, 1, 2, 1};
    tbl[7]  = '{1, 1, 4, 1, 3, 1};
    tbl[8]  = '{1, 1, 4, 1, 0, 1};
    tbl[9]  = '{2, 1, 3, 1, 0, 1};
    tbl[10] = '{2, 1, 2, 1, 0, 1};
    tbl[11] = '{2, 1, 1, 1, 0, 1};
    tbl[12] = '{2, 1, 0, 1, 0, 1};
    tbl[13] = '{2, 1, 0, 1, 0, 0};

    @(negedge pclk);
    do_reset();
    check("reset_col", piece_col, 4);
    check("reset_row", piece_row, 0);
    check("reset_rot", piece_rot, 0);
    check("reset_chk_req", chk_req, 0);
    check("reset_busy", busy, 0);
    check("reset_lock", lock, 0);
    check("reset_chk_col", chk_col, 4);

    // Table of single moves, position accumulating from reset
    for (int i = 0; i < 14; i++) begin
      srv_ok = tbl[i].ok;
      r0 = req_cnt;
      pulse(tbl[i].btn == 2, tbl[i].btn == 3, tbl[i].btn == 1, tbl[i].btn == 0, 1'b0);
      settle(10);
      check($sformatf("tbl%0d_req_cycles", i), req_cnt - r0, tbl[i].queried ? 2 : 0);
      check($sformatf("tbl%0d_col", i), piece_col, tbl[i].col);
      check($sformatf("tbl%0d_row", i), piece_row, tbl[i].row);
      check($sformatf("tbl%0d_rot", i), piece_rot, tbl[i].rot);
      check($sformatf("tbl%0d_busy", i), busy, 0);
    end
    srv_ok = 1'b1;

    // Right edge
    for (int i = 0; i < COL_MAX; i++) begin
      pulse(0, 1, 0, 0, 0);
      settle(10);
    end
    check("right_reach_col", piece_col, COL_MAX);
    r0 = req_cnt;
    pulse(0, 1, 0, 0, 0);
    settle(10);
    check("right_edge_noquery", req_cnt - r0, 0);
    check("right_edge_col", piece_col, COL_MAX);

    // Gravity every third frame tick
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      pulse(0, 0, 0, 0, 1);
      settle(8);
      check($sformatf("grav_tick%0d_row", k), piece_row, k / DF);
    end
    check("grav_req_cycles", req_cnt, 4);

    // Priority: gravity, rot and left arrive together
    do_reset();
    pulse(0, 0, 0, 0, 1); settle(2);
    pulse(0, 0, 0, 0, 1); settle(2);
    pulse(1, 0, 1, 0, 1);
    settle(20);
    check("prio_nqueries", qlog.size(), 3);
    if (qlog.size() == 3) begin
      check("prio_q0_down", qlog[0], {5'd4, 5'd1, 2'd0});
      check("prio_q1_rot",  qlog[1], {5'd4, 5'd1, 2'd1});
      check("prio_q2_left", qlog[2], {5'd3, 5'd1, 2'd1});
    end
    check("prio_col", piece_col, 3);
    check("prio_row", piece_row, 1);
    check("prio_rot", piece_rot, 1);

    // Landing at row 5, then frame counter must restart from 0
    do_reset();
    for (int i = 0; i < 5; i++) begin
      pulse(0, 0, 0, 1, 0);
      settle(10);
    end
    check("land_pre_row", piece_row, 5);
    pulse(0, 0, 0, 0, 1);
    settle(3);
    srv_ok = 1'b0;
    lock_cnt = 0;
    pulse(0, 0, 0, 1, 0);
    settle(10);
    srv_ok = 1'b1;
    check("land_lock_cycles", lock_cnt, 1);
    check("land_col", piece_col, 4);
    check("land_row", piece_row, 0);
    check("land_rot", piece_rot, 0);
    r0 = req_cnt;
    pulse(0, 0, 0, 0, 1); settle(4);
    pulse(0, 0, 0, 0, 1); settle(4);
    check("land_frames_cleared", req_cnt - r0, 0);
    pulse(0, 0, 0, 0, 1); settle(8);
    check("land_third_tick_query", req_cnt - r0, 2);
    check("land_third_tick_row", piece_row, 1);

    // Merge: three rot pulses during one slow query
    do_reset();
    srv_lat = 8;
    pulse(0, 0, 1, 0, 0);
    settle(2);
    check("merge_in_query", chk_req, 1);
    pulse(0, 0, 1, 0, 0);
    pulse(0, 0, 1, 0, 0);
    pulse(0, 0, 1, 0, 0);
    settle(40);
    check("merge_nqueries", qlog.size(), 2);
    check("merge_rot", piece_rot, 2);
    srv_lat = 2;

    // Reset in the middle of a query; late ack must be ignored
    do_reset();
    srv_lat = 1000;
    pulse(0, 0, 0, 1, 0);
    settle(3);
    check("rstq_pre_chk_req", chk_req, 1);
    rst = 1'b0;
    cyc();
    check("rstq_chk_req", chk_req, 0);
    check("rstq_busy", busy, 0);
    rst = 1'b1;
    chk_ack = 1'b1;
    chk_ok  = 1'b1;
    @(posedge pclk);
    @(negedge pclk);
    chk_ack = 1'b0;
    srv_lat = 2;
    settle(5);
    check("rstq_late_ack_row", piece_row, 0);
    check("rstq_late_ack_busy", busy, 0);
    check("rstq_late_ack_chk_req", chk_req, 0);

    // Randomized run against the reference model
    do_reset();
    m_phase = M_IDLE; m_col = 4; m_row = 0; m_rot = 0; m_frames = 0; m_mv = 0; m_ok = 0;
    c_col = 4; c_row = 0; c_rot = 0;
    w_down = 0; w_rot = 0; w_left = 0; w_right = 0;
    for (int cyc_i = 0; cyc_i < 1500; cyc_i++) begin
      check("rnd_chk_req", chk_req, m_phase == M_WAIT);
      check("rnd_busy", busy, m_phase != M_IDLE);
      check("rnd_lock", lock, (m_phase == M_DONE) && !m_ok && (m_mv == 0));
      check("rnd_piece_col", piece_col, m_col);
      check("rnd_piece_row", piece_row, m_row);
      check("rnd_piece_rot", piece_rot, m_rot);
      if (m_phase == M_WAIT) begin
        check("rnd_chk_col", chk_col, c_col);
        check("rnd_chk_row", chk_row, c_row);
        check("rnd_chk_rot", chk_rot, c_rot);
      end
      tick_frame = ($urandom_range(9) < 2);
      req_left   = ($urandom_range(15) == 0);
      req_right  = ($urandom_range(15) == 0);
      req_rot    = ($urandom_range(15) == 0);
      req_down   = ($urandom_range(15) == 0);
      chk_ack    = chk_req ? ($urandom_range(2) == 0) : ($urandom_range(31) == 0);
      chk_ok     = ($urandom_range(3) != 0) && (chk_row <= 5'd20);
      model_step();
      @(posedge pclk);
      @(negedge pclk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_n, err_n);
    $finish;
  end

endmodule
